// File: rtl/i2c_module.sv
// rtl/i2c_module.sv - I2C target with a small byte-wide register bank
//
// Purpose: oversampled I2C target. It decodes START/STOP, the 7-bit address,
// a register pointer and data bytes, and answers with ACKs and read data.
// Ports:
//   CLK   - system clock, all logic on the rising edge
//   Reset - asynchronous active-low reset
//   SCL   - I2C clock from the controller
//   iSDA  - I2C data as seen on the bus
//   oSDA  - target data drive, 0 = pull low, 1 = release
module i2c_module #(
  parameter logic [6:0] ADDRESS = 7'h50,
  parameter int         NREGS   = 16
) (
  input  logic CLK,
  input  logic Reset,
  input  logic SCL,
  input  logic iSDA,
  output logic oSDA
);

  localparam int PW = $clog2(NREGS);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WDATA, WACK, RDATA, RACK
  } stateT;

  stateT          state, stateNext;
  logic [1:0]     sclSync, sdaSync;
  logic           sclPrev, sdaPrev;
  logic [3:0]     bitCnt, cntNext;
  logic [7:0]     shiftReg, shiftNext;
  logic [PW-1:0]  ptr, ptrNext;
  logic           oSdaNext;
  logic           wrEn;
  logic [7:0]     regs [NREGS];
  logic [7:0]     rdByte;

  logic sclS, sdaS, sclRise, sclFall, startCond, stopCond;

  assign sclS    = sclSync[1];
  assign sdaS    = sdaSync[1];
  assign sclRise = sclS & ~sclPrev;
  assign sclFall = ~sclS & sclPrev;
  // SCL must be high on both samples so an SDA change that races an SCL
  // edge is never taken as a bus condition.
  assign startCond = sclS & sclPrev & sdaPrev & ~sdaS;
  assign stopCond  = sclS & sclPrev & ~sdaPrev & sdaS;
  assign rdByte    = regs[ptr];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sclSync  <= 2'b11;
      sdaSync  <= 2'b11;
      sclPrev  <= 1'b1;
      sdaPrev  <= 1'b1;
      state    <= IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      ptr      <= '0;
      oSDA     <= 1'b1;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      sclSync  <= {sclSync[0], SCL};
      sdaSync  <= {sdaSync[0], iSDA};
      sclPrev  <= sclS;
      sdaPrev  <= sdaS;
      state    <= stateNext;
      bitCnt   <= cntNext;
      shiftReg <= shiftNext;
      ptr      <= ptrNext;
      oSDA     <= oSdaNext;
      if (wrEn) regs[ptr] <= shiftReg;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = bitCnt;
    shiftNext = shiftReg;
    ptrNext   = ptr;
    oSdaNext  = oSDA;
    wrEn      = 1'b0;
    if (startCond) begin
      stateNext = ADDR;
      cntNext   = '0;
      oSdaNext  = 1'b1;
    end else if (stopCond) begin
      stateNext = IDLE;
      cntNext   = '0;
      oSdaNext  = 1'b1;
    end else begin
      case (state)
        IDLE: oSdaNext = 1'b1;
        ADDR, PTR, WDATA: begin
          if (sclRise && bitCnt < 4'd8) begin
            shiftNext = {shiftReg[6:0], sdaS};
            cntNext   = bitCnt + 4'd1;
          end else if (sclFall && bitCnt == 4'd8) begin
            // Falling edge after the 8th bit: decide the 9th (ACK) clock.
            cntNext   = '0;
            oSdaNext  = 1'b0;
            stateNext = WACK;
            if (state == ADDR) begin
              if (shiftReg[7:1] == ADDRESS) begin
                stateNext = ADDR_ACK;
              end else begin
                stateNext = IDLE;
                oSdaNext  = 1'b1;
              end
            end else if (state == PTR) begin
              ptrNext = shiftReg[PW-1:0];
            end else begin
              wrEn    = 1'b1;
              ptrNext = ptr + PW'(1);
            end
          end
        end
        ADDR_ACK: begin
          // shiftReg[0] still holds the R/W bit of the address byte.
          if (sclFall) begin
            if (shiftReg[0]) begin
              stateNext = RDATA;
              shiftNext = rdByte;
              oSdaNext  = rdByte[7];
            end else begin
              stateNext = PTR;
              oSdaNext  = 1'b1;
            end
          end
        end
        WACK: begin
          if (sclFall) begin
            stateNext = WDATA;
            oSdaNext  = 1'b1;
          end
        end
        RDATA: begin
          if (sclRise && bitCnt < 4'd8) begin
            cntNext = bitCnt + 4'd1;
          end else if (sclFall) begin
            if (bitCnt == 4'd8) begin
              oSdaNext  = 1'b1;
              cntNext   = '0;
              stateNext = RACK;
            end else if (bitCnt != 4'd0) begin
              shiftNext = {shiftReg[6:0], 1'b0};
              oSdaNext  = shiftReg[6];
            end
          end
        end
        RACK: begin
          // Controller ACK advances the pointer at the rising edge so the
          // following falling edge can present the next register directly.
          if (sclRise) begin
            if (sdaS) stateNext = IDLE;
            else      ptrNext   = ptr + PW'(1);
          end else if (sclFall) begin
            stateNext = RDATA;
            shiftNext = rdByte;
            oSdaNext  = rdByte[7];
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_module.sv
// tb/tb_i2c_module.sv - self-checking bench for i2c_module
module tb_i2c_module;

  logic clk = 1'b0;
  logic rstN;
  logic scl;
  logic msda;
  logic oSda;
  wire  busSda = msda & oSda;

  int errCnt = 0;
  int checkCnt = 0;

  logic [7:0] mem [16];
  int         mptr;
  logic [7:0] wbuf [8];

  always #5 clk = ~clk;

  i2c_module #(.ADDRESS(7'h50), .NREGS(16)) dut (
    .CLK   (clk),
    .Reset (rstN),
    .SCL   (scl),
    .iSDA  (busSda),
    .oSDA  (oSda)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; returns oSDA sampled in the middle of the high phase.
  task automatic clockBit(input logic b, output logic seen);
    scl = 1'b0;
    waitClk(5);
    msda = b;
    waitClk(5);
    scl = 1'b1;
    waitClk(5);
    seen = oSda;
    waitClk(5);
  endtask

  task automatic doStart();
    scl = 1'b0;
    waitClk(5);
    msda = 1'b1;
    waitClk(5);
    scl = 1'b1;
    waitClk(10);
    msda = 1'b0;
    waitClk(10);
  endtask

  task automatic doStop();
    scl = 1'b0;
    waitClk(5);
    msda = 1'b0;
    waitClk(5);
    scl = 1'b1;
    waitClk(10);
    msda = 1'b1;
    waitClk(10);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    logic s;
    logic rel;
    rel = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      clockBit(b[i], s);
      rel &= s;
    end
    checkVal("wr_bits_released", rel, 1);
    clockBit(1'b1, ack);
  endtask

  task automatic readByte(input logic ackBit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, s);
      d[i] = s;
    end
    clockBit(ackBit, s);
    checkVal("rd_ack_released", s, 1);
  endtask

  // wbuf[0] is the pointer byte, wbuf[1..n-1] are data bytes.
  task automatic writeTxn(input logic [7:0] addrB, input int n);
    logic ack;
    bit   match;
    match = (addrB[7:1] == 7'h50) && !addrB[0];
    doStart();
    sendByte(addrB, ack);
    checkVal("addr_ack", ack, match ? 0 : 1);
    for (int k = 0; k < n; k++) begin
      sendByte(wbuf[k], ack);
      checkVal("wdata_ack", ack, match ? 0 : 1);
      if (match) begin
        if (k == 0) begin
          mptr = int'(wbuf[0]) % 16;
        end else begin
          mem[mptr] = wbuf[k];
          mptr = (mptr + 1) % 16;
        end
      end
    end
    doStop();
  endtask

  task automatic readTxn(input bit setPtr, input logic [7:0] p, input int n);
    logic       ack;
    logic       nack;
    logic [7:0] d;
    doStart();
    if (setPtr) begin
      sendByte(8'hA0, ack);
      checkVal("rd_waddr_ack", ack, 0);
      sendByte(p, ack);
      checkVal("rd_ptr_ack", ack, 0);
      mptr = int'(p) % 16;
      doStart();
    end
    sendByte(8'hA1, ack);
    checkVal("raddr_ack", ack, 0);
    for (int k = 0; k < n; k++) begin
      nack = (k == n - 1);
      readByte(nack, d);
      checkVal("rdata", d, mem[mptr]);
      if (!nack) mptr = (mptr + 1) % 16;
    end
    doStop();
  endtask

  initial begin
    logic s;
    logic [7:0] a;
    int   n;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mptr = 0;
    scl  = 1'b1;
    msda = 1'b1;
    rstN = 1'b0;
    waitClk(4);
    checkVal("reset_osda", oSda, 1);
    rstN = 1'b1;
    waitClk(4);

    // Put something in reg 0, then reset while the target drives an ACK.
    wbuf[0] = 8'h00; wbuf[1] = 8'h77;
    writeTxn(8'hA0, 2);
    doStart();
    for (int i = 7; i >= 0; i--) clockBit(a_bit(8'hA0, i), s);
    scl = 1'b0;
    waitClk(5);
    checkVal("ack_before_reset", oSda, 0);
    rstN = 1'b0;
    #1;
    checkVal("reset_mid_osda", oSda, 1);
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mptr = 0;
    scl  = 1'b1;
    msda = 1'b1;
    waitClk(4);
    rstN = 1'b1;
    waitClk(4);
    readTxn(1'b1, 8'h00, 1);

    // Directed plan items.
    wbuf[0] = 8'h03; wbuf[1] = 8'h5A;
    writeTxn(8'hA0, 2);
    readTxn(1'b1, 8'h03, 1);
    wbuf[0] = 8'hFF;
    writeTxn(8'hA2, 1);
    wbuf[0] = 8'h0F; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
    writeTxn(8'hA0, 3);
    readTxn(1'b1, 8'h0F, 2);

    // STOP in the middle of a data byte: no write, pointer kept.
    doStart();
    sendByte(8'hA0, s);
    checkVal("mid_addr_ack", s, 0);
    sendByte(8'h07, s);
    checkVal("mid_ptr_ack", s, 0);
    mptr = 7;
    for (int i = 0; i < 4; i++) clockBit(i[0], s);
    doStop();
    checkVal("stop_mid_osda", oSda, 1);
    readTxn(1'b0, 8'h00, 1);

    // Randomized transactions against the register-bank model.
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, 3);
      case ($urandom_range(0, 3))
        0: begin
          wbuf[0] = 8'($urandom_range(0, 255));
          for (int k = 1; k <= n; k++) wbuf[k] = 8'($urandom_range(0, 255));
          writeTxn(8'hA0, n + 1);
        end
        1: readTxn(1'b1, 8'($urandom_range(0, 255)), n);
        2: readTxn(1'b0, 8'h00, n);
        default: begin
          a = {7'($urandom_range(0, 127)), 1'b0};
          if (a[7:1] == 7'h50) a = 8'hA4;
          for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom_range(0, 255));
          writeTxn(a, n);
        end
      endcase
    end

    readTxn(1'b1, 8'h00, 16);

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

  function automatic logic a_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
